// File: rtl/blk_14b975_pkg.sv
// Shared types and constants for the BCAM MBIST compare-result handler.
package arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } cm_state_t;

  localparam int CM_LATENCY_MAX = 4;
  localparam int FLOG_DEPTH     = 4;

endpackage

// File: rtl/blk_14b975_fail_pe.sv
// Lowest-index priority encoder: reports the first set bit of a vector and whether any bit is set.
module arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_fail_pe #(
  parameter int WIDTH = 96,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top so the lowest set index is the last assignment to win.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/blk_14b975.sv
// BCAM MBIST output handler: aligns expected hits to array compare latency and reports pass/fail.
// Optional fail-log FIFO is built when ARF_BCAM_MBIST_FAIL_LOG_EN is defined.
module blk_14b975
  import arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_pkg::*;
#(
  parameter int CAM_ENTRIES = 96,
  parameter int CM_LATENCY  = 2,
  parameter int FAIL_CNT_W  = 8,
  localparam int ADDR_W     = $clog2(CAM_ENTRIES)
) (
  input  logic                   bist_clk,
  input  logic                   rst_b,
  input  logic                   BIST_CM_MODE_RF_IN,
  input  logic                   BIST_CM_EN_RF_IN,
  input  logic [ADDR_W-1:0]      BIST_CM_ADDR_RF_IN,
  input  logic                   BIST_EXP_HIT_RF_IN,
  input  logic                   BIST_CLR_FAIL_RF_IN,
  input  logic [CAM_ENTRIES-1:0] CM_MATCH_RF_IN,
  output logic                   BIST_CM_CHK_VLD_RF_OUT,
  output logic                   BIST_CM_GO_RF_OUT,
  output logic                   BIST_CM_FAIL_STICKY_RF_OUT,
  output logic [FAIL_CNT_W-1:0]  BIST_CM_FAIL_CNT_RF_OUT,
  output logic [ADDR_W-1:0]      BIST_CM_FIRST_FAIL_RF_OUT,
  output logic                   BIST_CM_DONE_RF_OUT,
  input  logic                   BIST_FLOG_POP_RF_IN,
  output logic                   BIST_FLOG_VLD_RF_OUT,
  output logic [ADDR_W-1:0]      BIST_FLOG_ENTRY_RF_OUT,
  output logic                   BIST_FLOG_OVF_RF_OUT
);

  localparam logic [2:0]            DRAIN_LAST = 3'(CM_LATENCY);
  localparam logic [FAIL_CNT_W-1:0] CNT_MAX    = '1;

  cm_state_t  state_reg, state_next;
  logic [2:0] drain_reg, drain_next;
  logic       accept;

  always_ff @(posedge bist_clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= IDLE;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    drain_next          = drain_reg;
    BIST_CM_DONE_RF_OUT = 1'b0;
    case (state_reg)
      IDLE:  if (BIST_CM_MODE_RF_IN) state_next = RUN;
      RUN: begin
        drain_next = '0;
        if (!BIST_CM_MODE_RF_IN) state_next = DRAIN;
      end
      DRAIN: begin
        // Hold off DONE until the last accepted compare has been reported.
        if (BIST_CM_MODE_RF_IN)       state_next = RUN;
        else if (drain_reg == DRAIN_LAST) state_next = DONE;
        else                          drain_next = drain_reg + 3'd1;
      end
      DONE: begin
        BIST_CM_DONE_RF_OUT = 1'b1;
        state_next = BIST_CM_MODE_RF_IN ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = (state_reg == RUN) && BIST_CM_EN_RF_IN;

  // Expected-result delay line, tail lines up with the array's match vector.
  logic [CM_LATENCY-1:0] vld_pipe;
  logic [CM_LATENCY-1:0] exp_pipe;
  logic [ADDR_W-1:0]     addr_pipe [CM_LATENCY];

  always_ff @(posedge bist_clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_pipe <= '0;
      exp_pipe <= '0;
      for (int i = 0; i < CM_LATENCY; i++) addr_pipe[i] <= '0;
    end else begin
      vld_pipe[0]  <= accept;
      exp_pipe[0]  <= BIST_EXP_HIT_RF_IN;
      addr_pipe[0] <= BIST_CM_ADDR_RF_IN;
      for (int i = 1; i < CM_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        exp_pipe[i]  <= exp_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  logic                   tail_vld, tail_exp;
  logic [ADDR_W-1:0]      tail_addr;
  logic [CAM_ENTRIES-1:0] exp_vec, mismatch;
  logic [ADDR_W-1:0]      fail_idx;
  logic                   fail_any, fail;

  assign tail_vld  = vld_pipe[CM_LATENCY-1];
  assign tail_exp  = exp_pipe[CM_LATENCY-1];
  assign tail_addr = addr_pipe[CM_LATENCY-1];

  always_comb begin
    exp_vec = '0;
    if (tail_exp && (int'(tail_addr) < CAM_ENTRIES)) exp_vec[tail_addr] = 1'b1;
  end

  // Gate by tail valid so an undriven match bus never reaches the result logic.
  assign mismatch = tail_vld ? (exp_vec ^ CM_MATCH_RF_IN) : '0;

  arf096b192e1r1w0cbbeheaa4acw_bcam_mbist_fail_pe #(
    .WIDTH (CAM_ENTRIES),
    .IDX_W (ADDR_W)
  ) u_fail_pe (
    .vec (mismatch),
    .idx (fail_idx),
    .any (fail_any)
  );

  assign fail = tail_vld && fail_any;

  logic                  sticky_base, sticky_next;
  logic [FAIL_CNT_W-1:0] cnt_base, cnt_next;
  logic [ADDR_W-1:0]     first_base, first_next;

  always_comb begin
    sticky_base = BIST_CLR_FAIL_RF_IN ? 1'b0 : BIST_CM_FAIL_STICKY_RF_OUT;
    cnt_base    = BIST_CLR_FAIL_RF_IN ? '0   : BIST_CM_FAIL_CNT_RF_OUT;
    first_base  = BIST_CLR_FAIL_RF_IN ? '0   : BIST_CM_FIRST_FAIL_RF_OUT;
    sticky_next = sticky_base;
    cnt_next    = cnt_base;
    first_next  = first_base;
    if (fail) begin
      sticky_next = 1'b1;
      if (cnt_base != CNT_MAX) cnt_next = cnt_base + 1'b1;
      if (!sticky_base)        first_next = fail_idx;
    end
  end

  always_ff @(posedge bist_clk or negedge rst_b) begin
    if (!rst_b) begin
      BIST_CM_CHK_VLD_RF_OUT     <= 1'b0;
      BIST_CM_GO_RF_OUT          <= 1'b0;
      BIST_CM_FAIL_STICKY_RF_OUT <= 1'b0;
      BIST_CM_FAIL_CNT_RF_OUT    <= '0;
      BIST_CM_FIRST_FAIL_RF_OUT  <= '0;
    end else begin
      BIST_CM_CHK_VLD_RF_OUT     <= tail_vld;
      BIST_CM_GO_RF_OUT          <= tail_vld && !fail_any;
      BIST_CM_FAIL_STICKY_RF_OUT <= sticky_next;
      BIST_CM_FAIL_CNT_RF_OUT    <= cnt_next;
      BIST_CM_FIRST_FAIL_RF_OUT  <= first_next;
    end
  end

`ifdef ARF_BCAM_MBIST_FAIL_LOG_EN
  localparam int PTR_W = $clog2(FLOG_DEPTH);

  logic [ADDR_W-1:0] flog_mem [FLOG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              full, pop_ok, push_ok;

  assign full    = (count_reg == (PTR_W+1)'(FLOG_DEPTH));
  assign pop_ok  = BIST_FLOG_POP_RF_IN && (count_reg != '0);
  assign push_ok = fail && (!full || pop_ok);

  always_ff @(posedge bist_clk) begin
    if (push_ok) flog_mem[wr_ptr_reg] <= fail_idx;
  end

  always_ff @(posedge bist_clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_reg           <= '0;
      rd_ptr_reg           <= '0;
      count_reg            <= '0;
      BIST_FLOG_OVF_RF_OUT <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (BIST_CLR_FAIL_RF_IN)   BIST_FLOG_OVF_RF_OUT <= 1'b0;
      if (fail && full && !pop_ok) BIST_FLOG_OVF_RF_OUT <= 1'b1;
    end
  end

  assign BIST_FLOG_VLD_RF_OUT   = (count_reg != '0);
  assign BIST_FLOG_ENTRY_RF_OUT = BIST_FLOG_VLD_RF_OUT ? flog_mem[rd_ptr_reg] : '0;
`else
  logic unused_pop;
  assign unused_pop             = BIST_FLOG_POP_RF_IN;
  assign BIST_FLOG_VLD_RF_OUT   = 1'b0;
  assign BIST_FLOG_ENTRY_RF_OUT = '0;
  assign BIST_FLOG_OVF_RF_OUT   = 1'b0;
`endif

endmodule

// File: tb/tb_blk_14b975.sv
// Directed self-checking bench for blk_14b975 (CAM_ENTRIES=96, CM_LATENCY=2, FAIL_CNT_W=8).
module tb_blk_14b975;

  logic        bist_clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        mode = 1'b0, en = 1'b0, exp_hit = 1'b0, clr = 1'b0, pop = 1'b0;
  logic [6:0]  addr = '0;
  logic [95:0] match = '1;
  logic        chk_vld, go, sticky, done, flog_vld, flog_ovf;
  logic [7:0]  cnt;
  logic [6:0]  first, flog_entry;

  int passed = 0;
  int total  = 0;

  always #5 bist_clk = ~bist_clk;

  blk_14b975 dut (
    .bist_clk                   (bist_clk),
    .rst_b                      (rst_b),
    .BIST_CM_MODE_RF_IN         (mode),
    .BIST_CM_EN_RF_IN           (en),
    .BIST_CM_ADDR_RF_IN         (addr),
    .BIST_EXP_HIT_RF_IN         (exp_hit),
    .BIST_CLR_FAIL_RF_IN        (clr),
    .CM_MATCH_RF_IN             (match),
    .BIST_CM_CHK_VLD_RF_OUT     (chk_vld),
    .BIST_CM_GO_RF_OUT          (go),
    .BIST_CM_FAIL_STICKY_RF_OUT (sticky),
    .BIST_CM_FAIL_CNT_RF_OUT    (cnt),
    .BIST_CM_FIRST_FAIL_RF_OUT  (first),
    .BIST_CM_DONE_RF_OUT        (done),
    .BIST_FLOG_POP_RF_IN        (pop),
    .BIST_FLOG_VLD_RF_OUT       (flog_vld),
    .BIST_FLOG_ENTRY_RF_OUT     (flog_entry),
    .BIST_FLOG_OVF_RF_OUT       (flog_ovf)
  );

  function automatic logic [95:0] oh(input int i);
    logic [95:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge bist_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Issue one compare, return with outputs showing its registered result.
  task automatic compare(input int a, input logic e, input logic [95:0] m, input logic c);
    en = 1'b1; addr = 7'(a); exp_hit = e;
    step();
    en = 1'b0;
    step();
    match = m; clr = c;
    step();
    match = '1; clr = 1'b0;
  endtask

  initial begin
    step(); step();
    check("rst_chk_vld", chk_vld, 0);
    check("rst_go", go, 0);
    check("rst_sticky", sticky, 0);
    check("rst_cnt", cnt, 0);
    check("rst_first", first, 0);
    check("rst_done", done, 0);
    rst_b = 1'b1;
    step();
    mode = 1'b1;
    step();

    compare(5, 1'b1, oh(5), 1'b0);
    $display("txn hit addr=5 match=oh5 chk=%0d go=%0d cnt=%0d", chk_vld, go, cnt);
    check("t1_chk_vld", chk_vld, 1);
    check("t1_go", go, 1);
    check("t1_sticky", sticky, 0);
    check("t1_cnt", cnt, 0);
    step();
    check("t1_chk_vld_drop", chk_vld, 0);

    compare(5, 1'b1, oh(5) | oh(17), 1'b0);
    $display("txn hit addr=5 match={5,17} go=%0d cnt=%0d first=%0d", go, cnt, first);
    check("t2_go", go, 0);
    check("t2_sticky", sticky, 1);
    check("t2_cnt", cnt, 1);
    check("t2_first", first, 17);
    compare(3, 1'b1, '0, 1'b0);
    $display("txn hit addr=3 match=0 cnt=%0d first=%0d", cnt, first);
    check("t2b_cnt", cnt, 2);
    check("t2b_first", first, 17);

    compare(40, 1'b0, '0, 1'b0);
    $display("txn miss addr=40 match=0 go=%0d", go);
    check("miss_go", go, 1);
    compare(100, 1'b1, '0, 1'b0);
    $display("txn hit addr=100 (out of range) match=0 go=%0d", go);
    check("oor_go", go, 1);
    compare(95, 1'b1, oh(95), 1'b0);
    $display("txn hit addr=95 match=oh95 go=%0d cnt=%0d", go, cnt);
    check("top_go", go, 1);
    check("top_cnt", cnt, 2);

    en = 1'b1; exp_hit = 1'b1; addr = 7'd10;
    step();
    addr = 7'd11;
    step();
    en = 1'b0; match = oh(10);
    step();
    $display("txn b2b A addr=10 go=%0d", go);
    check("b2b_a_go", go, 1);
    match = oh(12);
    step();
    match = '1;
    $display("txn b2b B addr=11 match=oh12 chk=%0d go=%0d cnt=%0d first=%0d", chk_vld, go, cnt, first);
    check("b2b_b_chk", chk_vld, 1);
    check("b2b_b_go", go, 0);
    check("b2b_b_cnt", cnt, 3);
    check("b2b_b_first", first, 17);

    en = 1'b1; exp_hit = 1'b0; addr = 7'd0; match = oh(7);
    for (int i = 0; i < 300; i++) step();
    en = 1'b0;
    step(); step(); step();
    match = '1;
    $display("txn 300 fails cnt=%0d sticky=%0d", cnt, sticky);
    check("sat_cnt", cnt, 255);
    check("sat_first", first, 17);
    compare(20, 1'b1, '0, 1'b1);
    $display("txn clr+fail addr=20 cnt=%0d sticky=%0d first=%0d", cnt, sticky, first);
    check("clrfail_cnt", cnt, 1);
    check("clrfail_sticky", sticky, 1);
    check("clrfail_first", first, 20);
    clr = 1'b1;
    step();
    clr = 1'b0;
    $display("txn clr cnt=%0d sticky=%0d", cnt, sticky);
    check("clr_cnt", cnt, 0);
    check("clr_sticky", sticky, 0);
    check("clr_first", first, 0);

    en = 1'b1; exp_hit = 1'b1; addr = 7'd30;
    step();
    addr = 7'd31;
    step();
    en = 1'b0; mode = 1'b0; match = oh(30);
    step();
    $display("txn drain A addr=30 chk=%0d go=%0d", chk_vld, go);
    check("drain_a_chk", chk_vld, 1);
    check("drain_a_go", go, 1);
    match = oh(31);
    step();
    match = '1;
    $display("txn drain B addr=31 chk=%0d go=%0d done=%0d", chk_vld, go, done);
    check("drain_b_chk", chk_vld, 1);
    check("drain_b_go", go, 1);
    check("drain_done_early1", done, 0);
    step();
    check("drain_done_early2", done, 0);
    step();
    $display("txn done pulse done=%0d", done);
    check("drain_done", done, 1);
    step();
    check("drain_done_once", done, 0);

    en = 1'b1; addr = 7'd0;
    step();
    en = 1'b0;
    step(); step();
    $display("txn en in IDLE chk=%0d cnt=%0d", chk_vld, cnt);
    check("idle_en_chk", chk_vld, 0);
    check("idle_en_cnt", cnt, 0);

    mode = 1'b1;
    step();
    compare(8, 1'b1, '0, 1'b0);
    check("pre_rst_sticky", sticky, 1);
    en = 1'b1; addr = 7'd9;
    step(); step();
    en = 1'b0;
    #2 rst_b = 1'b0;
    #1;
    $display("txn async reset sticky=%0d cnt=%0d chk=%0d", sticky, cnt, chk_vld);
    check("arst_sticky", sticky, 0);
    check("arst_cnt", cnt, 0);
    check("arst_first", first, 0);
    check("arst_chk", chk_vld, 0);
    step();
    rst_b = 1'b1;
    step(); step();
    check("post_rst_chk1", chk_vld, 0);
    step();
    check("post_rst_chk2", chk_vld, 0);
    check("post_rst_cnt", cnt, 0);

`ifdef ARF_BCAM_MBIST_FAIL_LOG_EN
    compare(1, 1'b0, oh(1), 1'b0);
    compare(2, 1'b0, oh(2), 1'b0);
    compare(3, 1'b0, oh(3), 1'b0);
    compare(4, 1'b0, oh(4), 1'b0);
    compare(9, 1'b0, oh(9), 1'b0);
    $display("txn flog 5 fails vld=%0d head=%0d ovf=%0d cnt=%0d", flog_vld, flog_entry, flog_ovf, cnt);
    check("flog_cnt", cnt, 5);
    check("flog_first", first, 1);
    check("flog_vld", flog_vld, 1);
    check("flog_head1", flog_entry, 1);
    check("flog_ovf", flog_ovf, 1);
    pop = 1'b1;
    step();
    check("flog_head2", flog_entry, 2);
    step();
    check("flog_head3", flog_entry, 3);
    step();
    check("flog_head4", flog_entry, 4);
    step();
    $display("txn flog drained vld=%0d", flog_vld);
    check("flog_empty", flog_vld, 0);
    step();
    check("flog_pop_empty", flog_vld, 0);
    pop = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    check("flog_ovf_clr", flog_ovf, 0);
`else
    compare(9, 1'b0, oh(9), 1'b0);
    pop = 1'b1;
    step();
    pop = 1'b0;
    $display("txn flog absent vld=%0d entry=%0d ovf=%0d", flog_vld, flog_entry, flog_ovf);
    check("noflog_cnt", cnt, 1);
    check("noflog_vld", flog_vld, 0);
    check("noflog_entry", flog_entry, 0);
    check("noflog_ovf", flog_ovf, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
